// File: rtl/sti_pkg.sv
// Shared encodings for the STI command scheduler: FSM states, command field offsets and
// word-length codes.
package sti_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StGap,
        StEnd,
        StDone
    } sti_state_e;

    localparam int unsigned CMD_W       = 22;
    localparam int unsigned CMD_LAST    = 21;
    localparam int unsigned CMD_MSB     = 20;
    localparam int unsigned CMD_LOW     = 19;
    localparam int unsigned CMD_FILL    = 18;
    localparam int unsigned CMD_LEN_HI  = 17;
    localparam int unsigned CMD_LEN_LO  = 16;
    localparam int unsigned CMD_DATA_HI = 15;
    localparam int unsigned CMD_DATA_LO = 0;

    localparam logic [1:0] LEN_8  = 2'd0;
    localparam logic [1:0] LEN_16 = 2'd1;
    localparam logic [1:0] LEN_24 = 2'd2;
    localparam logic [1:0] LEN_32 = 2'd3;

    // Final SHIFT counter value for a word: N+1 with N = 8*(length+1).
    function automatic logic [5:0] shift_last(input logic [1:0] len);
        logic [5:0] last;
        last = 6'd33;
        case (len)
            LEN_8:   last = 6'd9;
            LEN_16:  last = 6'd17;
            LEN_24:  last = 6'd25;
            LEN_32:  last = 6'd33;
            default: last = 6'd33;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/sti_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant while enabled; on an accept the pointer moves to
// the requester that did not win.
module sti_rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output logic       id_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        id_o  = (req_i == 2'b11) ? ptr_q : req_i[1];
        gnt_o = 2'b00;
        if (en_i && (req_i != 2'b00)) begin
            gnt_o = id_o ? 2'b10 : 2'b01;
        end
        ptr_d = (gnt_o != 2'b00) ? ~id_o : ptr_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sti_cmd_scheduler.sv
// STI serializer front end: arbitrates two command requesters, presents one word at a time on
// pi_* with a load pulse, and closes the session with pi_end / oem_finish handshaking.
module sti_cmd_scheduler
    import sti_pkg::*;
#(
    parameter int unsigned GAP_CYC = 1,
    parameter int unsigned FIN_TMO = 512
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        rq_valid,
    output logic [1:0]        rq_ready,
    input  logic [CMD_W-1:0]  rq0_cmd,
    input  logic [CMD_W-1:0]  rq1_cmd,
    output logic              load,
    output logic [15:0]       pi_data,
    output logic [1:0]        pi_length,
    output logic              pi_fill,
    output logic              pi_msb,
    output logic              pi_low,
    output logic              pi_end,
    input  logic              so_valid,
    input  logic              oem_finish,
    output logic              grant_id,
    output logic              busy,
    output logic              done,
    output logic              err_nv,
    output logic              err_tmo
);

    localparam int unsigned     TmoW    = $clog2(FIN_TMO + 1);
    localparam logic [3:0]      GapLast = 4'(GAP_CYC - 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(FIN_TMO - 1);

    sti_state_e       state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [3:0]       gap_q, gap_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             gid_q, gid_d;
    logic             pi_end_q, pi_end_d;
    logic             done_q, done_d;
    logic             err_nv_q, err_nv_d;
    logic             err_tmo_q, err_tmo_d;

    logic [1:0]       arb_gnt;
    logic             arb_id;
    logic             accept;

    sti_rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (state_q == StIdle),
        .req_i   (rq_valid),
        .gnt_o   (arb_gnt),
        .id_o    (arb_id)
    );

    assign accept = (arb_gnt != 2'b00);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        tmo_d     = tmo_q;
        cmd_d     = cmd_q;
        gid_d     = gid_q;
        pi_end_d  = pi_end_q;
        done_d    = done_q;
        err_nv_d  = err_nv_q;
        err_tmo_d = err_tmo_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cmd_d   = arb_id ? rq1_cmd : rq0_cmd;
                    gid_d   = arb_id;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                cnt_d   = '0;
                state_d = StShift;
            end
            StShift: begin
                // The serializer must report valid output one cycle into the shift.
                if ((cnt_q == 6'd1) && !so_valid) begin
                    err_nv_d = 1'b1;
                end
                if (cnt_q == shift_last(cmd_q[CMD_LEN_HI:CMD_LEN_LO])) begin
                    gap_d   = '0;
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    if (cmd_q[CMD_LAST]) begin
                        pi_end_d = 1'b1;
                        tmo_d    = '0;
                        state_d  = StEnd;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            StEnd: begin
                // Finish has priority over a timeout expiring in the same cycle.
                if (oem_finish) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else if (tmo_q == TmoLast) begin
                    err_tmo_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            gap_q     <= '0;
            tmo_q     <= '0;
            cmd_q     <= '0;
            gid_q     <= 1'b0;
            pi_end_q  <= 1'b0;
            done_q    <= 1'b0;
            err_nv_q  <= 1'b0;
            err_tmo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            tmo_q     <= tmo_d;
            cmd_q     <= cmd_d;
            gid_q     <= gid_d;
            pi_end_q  <= pi_end_d;
            done_q    <= done_d;
            err_nv_q  <= err_nv_d;
            err_tmo_q <= err_tmo_d;
        end
    end

    assign rq_ready  = arb_gnt;
    assign load      = (state_q == StLoad);
    assign pi_data   = cmd_q[CMD_DATA_HI:CMD_DATA_LO];
    assign pi_length = cmd_q[CMD_LEN_HI:CMD_LEN_LO];
    assign pi_fill   = cmd_q[CMD_FILL];
    assign pi_msb    = cmd_q[CMD_MSB];
    assign pi_low    = cmd_q[CMD_LOW];
    assign pi_end    = pi_end_q;
    assign grant_id  = gid_q;
    assign busy      = (state_q != StIdle) && (state_q != StDone);
    assign done      = done_q;
    assign err_nv    = err_nv_q;
    assign err_tmo   = err_tmo_q;

endmodule

// File: tb/tb_sti_cmd_scheduler.sv
// Self-checking bench for sti_cmd_scheduler: a transaction-timing reference model predicts
// grants, load pulses, held pi_* values and the END/DONE outcome.
module tb_sti_cmd_scheduler;

    localparam int GAP = 2;
    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  rq_valid = 2'b00;
    logic [1:0]  rq_ready;
    logic [21:0] rq0_cmd = '0;
    logic [21:0] rq1_cmd = '0;
    logic        load;
    logic [15:0] pi_data;
    logic [1:0]  pi_length;
    logic        pi_fill, pi_msb, pi_low, pi_end;
    logic        so_valid = 1'b1;
    logic        oem_finish = 1'b0;
    logic        grant_id, busy, done, err_nv, err_tmo;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    sti_cmd_scheduler #(
        .GAP_CYC (GAP),
        .FIN_TMO (TMO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rq_valid   (rq_valid),
        .rq_ready   (rq_ready),
        .rq0_cmd    (rq0_cmd),
        .rq1_cmd    (rq1_cmd),
        .load       (load),
        .pi_data    (pi_data),
        .pi_length  (pi_length),
        .pi_fill    (pi_fill),
        .pi_msb     (pi_msb),
        .pi_low     (pi_low),
        .pi_end     (pi_end),
        .so_valid   (so_valid),
        .oem_finish (oem_finish),
        .grant_id   (grant_id),
        .busy       (busy),
        .done       (done),
        .err_nv     (err_nv),
        .err_tmo    (err_tmo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: word timing expressed as absolute cycle numbers.
    logic [21:0] q0[$];
    logic [21:0] q1[$];
    logic [21:0] cur;
    bit          cur_gid;
    int          rr_m, idle_at, acc_at, end_at, first_acc, nacc;
    bit          ended, nv_tie, rand_hold, keep_b_valid;
    int          gids[$];

    function automatic logic [21:0] mk_cmd(input bit last, input bit msb, input bit low,
                                           input bit fill, input logic [1:0] len,
                                           input logic [15:0] data);
        return {last, msb, low, fill, len, data};
    endfunction

    task automatic model_reset();
        rr_m = 0; idle_at = cyc; acc_at = -100; end_at = 0; first_acc = -100; nacc = 0;
        ended = 0; cur = '0; cur_gid = 0; gids.delete();
        q0.delete(); q1.delete();
        nv_tie = 0; rand_hold = 0; keep_b_valid = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rq_valid = 2'b00; oem_finish = 1'b0; so_valid = 1'b1; reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic run_words(input int max_cyc, input bit must_drain);
        int c;
        bit idle, w, drained;
        logic [1:0] exp_rdy;
        drained = 0;
        for (int k = 0; k < max_cyc && !drained; k++) begin
            @(posedge clk); #1;
            rq_valid[0] = (q0.size() > 0) && (!rand_hold || $urandom_range(0, 3) != 0);
            rq_valid[1] = (q1.size() > 0 || (keep_b_valid && ended))
                          && (!rand_hold || $urandom_range(0, 3) != 0);
            rq0_cmd = (q0.size() > 0) ? q0[0] : 22'($urandom);
            rq1_cmd = (q1.size() > 0) ? q1[0] : 22'($urandom);
            oem_finish = rand_hold && ($urandom_range(0, 7) == 0);
            so_valid = !nv_tie;
            @(negedge clk);
            c = cyc;
            idle = !ended && (c >= idle_at);
            exp_rdy = 2'b00;
            if (idle) exp_rdy = (rq_valid == 2'b11) ? (rr_m != 0 ? 2'b10 : 2'b01) : rq_valid;
            checks++;
            if (rq_ready !== exp_rdy) begin
                errors++; $display("FAIL rq_ready @%0d: got %b exp %b", c, rq_ready, exp_rdy);
            end
            checks++;
            if (load !== 1'(c == acc_at + 1)) begin
                errors++; $display("FAIL load @%0d: got %b exp %b", c, load, c == acc_at + 1);
            end
            if (!ended || c < end_at) begin
                checks++;
                if (busy !== !idle) begin
                    errors++; $display("FAIL busy @%0d: got %b exp %b", c, busy, !idle);
                end
            end
            checks++;
            if ({pi_data, pi_length, pi_fill, pi_msb, pi_low} !==
                {cur[15:0], cur[17:16], cur[18], cur[20], cur[19]}) begin
                errors++;
                $display("FAIL pi_fields @%0d: got %h/%0d/%b%b%b exp %h/%0d/%b%b%b", c,
                         pi_data, pi_length, pi_fill, pi_msb, pi_low,
                         cur[15:0], cur[17:16], cur[18], cur[20], cur[19]);
            end
            checks++;
            if (grant_id !== cur_gid) begin
                errors++; $display("FAIL grant_id @%0d: got %b exp %b", c, grant_id, cur_gid);
            end
            checks++;
            if (pi_end !== 1'(ended && c >= end_at)) begin
                errors++; $display("FAIL pi_end @%0d: got %b exp %b", c, pi_end,
                                   ended && c >= end_at);
            end
            checks++;
            if (err_nv !== 1'(nv_tie && nacc > 0 && c >= first_acc + 4)) begin
                errors++; $display("FAIL err_nv @%0d: got %b", c, err_nv);
            end
            checks++;
            if ({done, err_tmo} !== 2'b00) begin
                errors++; $display("FAIL done_tmo_early @%0d: got %b%b exp 00", c, done, err_tmo);
            end
            if (exp_rdy != 2'b00) begin
                w = exp_rdy[1];
                cur = w ? rq1_cmd : rq0_cmd;
                cur_gid = w;
                if (w && q1.size() > 0) q1.delete(0);
                if (!w && q0.size() > 0) q0.delete(0);
                rr_m = w ? 0 : 1;
                acc_at = c;
                gids.push_back(int'(w));
                if (nacc == 0) first_acc = c;
                nacc++;
                idle_at = c + 8 * (int'(cur[17:16]) + 1) + 4 + GAP;
                if (cur[21]) begin
                    ended = 1;
                    end_at = idle_at;
                end
            end
            if (must_drain && q0.size() == 0 && q1.size() == 0 &&
                (ended ? (c >= end_at) : (c >= idle_at))) drained = 1;
        end
        if (must_drain && !drained) begin
            errors++; $display("FAIL drain_timeout: got pending words, exp drained in %0d", max_cyc);
        end
    endtask

    // Steps through END: finish pulse in END cycle fin_at (or none if outside 0..TMO-1).
    task automatic run_end(input int fin_at, input int ncyc);
        bit fin_ok;
        int resolved;
        fin_ok = (fin_at >= 0) && (fin_at < TMO);
        resolved = fin_ok ? fin_at + 1 : TMO;
        for (int j = 1; j <= ncyc; j++) begin
            @(posedge clk); #1;
            rq_valid = 2'b11;
            oem_finish = (j == fin_at);
            @(negedge clk);
            checks++;
            if ({done, err_tmo} !== {1'(fin_ok && j >= resolved), 1'(!fin_ok && j >= TMO)}) begin
                errors++; $display("FAIL end_outcome j=%0d: got done=%b tmo=%b", j, done, err_tmo);
            end
            checks++;
            if (busy !== 1'(j < resolved)) begin
                errors++; $display("FAIL end_busy j=%0d: got %b exp %b", j, busy, j < resolved);
            end
            checks++;
            if ({rq_ready, load, pi_end} !== 4'b0001) begin
                errors++; $display("FAIL end_outputs j=%0d: got %b exp 0001", j,
                                   {rq_ready, load, pi_end});
            end
        end
        oem_finish = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rq_valid = 2'b00; reset_n = 1'b0; #1;
        checks++;
        if ({rq_ready, load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
             grant_id, busy, done, err_nv, err_tmo} !== 29'd0) begin
            errors++; $display("FAIL reset_outputs: got nonzero outputs, exp all 0");
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        checks++;
        if ({busy, rq_ready, load} !== 4'b0000) begin
            errors++; $display("FAIL reset_idle: got %b exp 0000", {busy, rq_ready, load});
        end
    endtask

    task automatic test_single();
        do_reset();
        q0.push_back(mk_cmd(0, 1, 0, 0, 2'd0, 16'hA5C3));
        run_words(60, 1);
        checks++;
        if (gids.size() != 1 || gids[0] != 0) begin
            errors++; $display("FAIL single_grant: got %0d grants, exp one from req0", gids.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            q0.push_back(mk_cmd(0, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                                16'($urandom)));
            q1.push_back(mk_cmd(0, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                                16'($urandom)));
        end
        run_words(300, 1);
        checks++;
        if (gids.size() != 4 || gids[0] != 0 || gids[1] != 1 || gids[2] != 0 || gids[3] != 1)
        begin
            errors++; $display("FAIL b2b_sequence: got %p exp 0,1,0,1", gids);
        end
    endtask

    task automatic test_random();
        do_reset();
        rand_hold = 1;
        for (int i = 0; i < 6; i++) begin
            q0.push_back(mk_cmd(0, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                                16'($urandom)));
            q1.push_back(mk_cmd(0, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                                16'($urandom)));
        end
        run_words(3000, 1);
        rand_hold = 0;
    endtask

    task automatic test_end_finish();
        do_reset();
        keep_b_valid = 1;
        q0.push_back(mk_cmd(0, 0, 1, 0, 2'd3, 16'h1234));
        q0.push_back(mk_cmd(1, 1, 0, 1, 2'd0, 16'hBEEF));
        run_words(300, 1);
        run_end(5, 12);
        checks++;
        if (gids.size() != 2 || gids[0] != 0 || gids[1] != 0) begin
            errors++; $display("FAIL end_grants: got %p exp 0,0", gids);
        end
    endtask

    task automatic test_nv();
        do_reset();
        nv_tie = 1;
        q0.push_back(mk_cmd(0, 0, 0, 0, 2'($urandom), 16'($urandom)));
        run_words(100, 1);
        checks++;
        if (err_nv !== 1'b1) begin
            errors++; $display("FAIL nv_sticky: got %b exp 1", err_nv);
        end
        nv_tie = 0;
    endtask

    task automatic test_timeout();
        do_reset();
        q0.push_back(mk_cmd(1, 0, 0, 0, 2'($urandom), 16'($urandom)));
        run_words(100, 1);
        run_end(-1, TMO + 4);
    endtask

    task automatic test_finish_race();
        do_reset();
        q1.push_back(mk_cmd(1, 1, 1, 1, 2'd1, 16'($urandom)));
        run_words(100, 1);
        run_end(TMO - 1, TMO + 3);
    endtask

    task automatic test_reset_mid();
        do_reset();
        q0.push_back(mk_cmd(0, 0, 1, 1, 2'd3, 16'h5A5A));
        run_words(10, 0);
        #2;
        rq_valid = 2'b00; reset_n = 1'b0; #1;
        checks++;
        if ({rq_ready, load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
             grant_id, busy, done, err_nv, err_tmo} !== 29'd0) begin
            errors++; $display("FAIL reset_mid_outputs: got nonzero outputs, exp all 0");
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        q0.push_back(mk_cmd(0, 0, 0, 0, 2'd0, 16'h0F0F));
        q1.push_back(mk_cmd(0, 1, 0, 0, 2'd1, 16'hF0F0));
        run_words(200, 1);
        checks++;
        if (gids.size() != 2 || gids[0] != 0) begin
            errors++; $display("FAIL reset_mid_rr: got %p exp first grant 0", gids);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_random();
        test_end_finish();
        test_nv();
        test_timeout();
        test_finish_race();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, exp finished");
        $fatal(1, "watchdog expired");
    end

endmodule
